mem_bridge: RTL and testbench
=============================

Name: mem_bridge

Overview:
- Memory-side stage directly downstream of the CPU core. Converts CPU word requests into accesses on a single-port synchronous SRAM with a fixed number of wait states.
- Contains a one-entry posted-write buffer, read-after-write forwarding from that buffer, and out-of-range address detection.
- Sits between the CPU address/data/write-enable outputs and the instruction/data RAM.

Parameters:
- DATA_W, 32, width of CPU and memory data words.
- MEM_AW, 10, SRAM word-address width; implemented space is 2^MEM_AW words.
- WAIT_STATES, 2, extra SRAM cycles per access (0..15).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held with all fields stable until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid when cpu_ready=1 and cpu_we=0.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  out-of-range flag, qualified by cpu_ready.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, write buffer invalid, FSM in IDLE, wait counter 0. A buffered write still pending at reset is discarded.
- All outputs are registered.
- SRAM contract: on a read, mem_rdata is valid WAIT_STATES+1 cycles after the first cycle with mem_en=1. For every access, mem_en/mem_we/mem_addr/mem_wdata are held constant for WAIT_STATES+1 cycles.
- FSM states:
  - IDLE: accepts a new request.
  - RD_ISSUE: drives the SRAM read for WAIT_STATES+1 cycles.
  - RD_CAPTURE: registers mem_rdata into cpu_rdata and pulses cpu_ready.
  - STALL: waits for the write buffer to drain.
- Write buffer: valid bit, address, data. Drain runs independently of the FSM whenever the valid bit is set and no read is issuing; the valid bit clears at the end of the WAIT_STATES+1 window.
- Request sampled in IDLE at cycle T:
  - Out of range (cpu_addr[31:MEM_AW] != 0): cpu_ready=1 and cpu_err=1 at T+1, cpu_rdata=0, no SRAM access, write dropped.
  - Write, buffer empty: captured into the buffer, cpu_ready at T+1 (posted). Drain starts at T+1.
  - Write, buffer valid: go to STALL; accept the write in the cycle after the drain completes, cpu_ready one cycle later. No write merging, even to the same address.
  - Read, buffer valid and addresses equal: cpu_rdata=buffer data, cpu_ready at T+1, no SRAM access; the drain continues.
  - Read, buffer valid and addresses differ: go to STALL until the drain completes, then RD_ISSUE.
  - Read, buffer empty: mem_en=1 and mem_we=0 from T+1 to T+1+WAIT_STATES; data captured at T+2+WAIT_STATES; cpu_ready at T+3+WAIT_STATES (T+5 at the default).
- In the cycle cpu_ready=1 the FSM returns to IDLE. cpu_req is not sampled again until the following cycle, so a back-to-back request has one idle cycle.
- cpu_ready and cpu_err are single-cycle pulses. cpu_rdata holds its value until the next read completion.
- cpu_req dropped before cpu_ready is a protocol violation; behaviour is undefined and an assertion fires.

Decomposition:
- Package jif_mem_pkg: FSM state enum (IDLE, RD_ISSUE, RD_CAPTURE, STALL), a WAIT_W localparam (4 bits) and a default-width constant.
- One sub-module, mem_wait_timer:
  - Loadable down-counter with a done pulse.
  - Loaded with WAIT_STATES at access start; done when the count reaches 0.
  - Shared by the read-issue and write-drain paths, which are mutually exclusive.

Test Plan:
- Reset mid-drain: write 0xDEADBEEF to addr 5, assert reset at T+2 -> all outputs 0 immediately; after release, a read of addr 5 returns the initial SRAM content, not 0xDEADBEEF.
- Cold read, W=2: SRAM[0x010]=0x12345678, read addr 0x10 at T -> mem_en high T+1..T+3, cpu_ready and cpu_rdata=0x12345678 at T+5.
- Posted write then forwarded read: write 0xCAFEF00D to addr 3 (ready at T+1), read addr 3 at T+2 -> ready at T+3 with 0xCAFEF00D, no read strobe on the SRAM; SRAM[3]=0xCAFEF00D after the drain.
- Back-to-back writes: write addr 1 then addr 2 -> second write stalls until the first drain ends (mem_we high 3 cycles per write), second ready one cycle after acceptance.
- Read miss during drain: write addr 7, then read addr 8 -> read mem_en starts only after the write window closes; returned data comes from SRAM[8].
- Out of range with MEM_AW=10: write to addr 0x400 -> cpu_ready=1 and cpu_err=1 at T+1, mem_en stays 0, SRAM unchanged.

Source files
------------

// File: rtl/jif_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jif_mem_pkg
// Brief   : Shared types and constants for the CPU-to-SRAM memory bridge.
// Revision: 1.0 - initial release
// ============================================================================
package jif_mem_pkg;

  // Bridge control states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    STALL      = 2'd3
  } state_e;

  // Width of the wait-state counter (supports 0..15 wait states)
  localparam int WAIT_W = 4;

  // Default CPU / memory data word width
  localparam int DEF_DATA_W = 32;

endpackage : jif_mem_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : mem_wait_timer
// Brief   : Loadable down-counter timing one SRAM access window. Loaded with
//           the wait-state count at access start; done_o is high during the
//           last cycle of the window (count reached zero).
// Revision: 1.0 - initial release
// ============================================================================
module mem_wait_timer
  import jif_mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;

  // Next count: reload on a new access, otherwise count down to zero and stop
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = load_val_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done_o = active_q && (cnt_q == '0);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : mem_bridge
// Brief   : CPU word-request to single-port synchronous SRAM bridge with fixed
//           wait states, a one-entry posted-write buffer, read-after-write
//           forwarding and out-of-range detection. All outputs registered.
// Revision: 1.0 - initial release
// ============================================================================
module mem_bridge
  import jif_mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic [MEM_AW-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;

  logic                in_range;
  logic                wb_hit;
  logic                accept_wr;
  logic                start_rd;
  logic                tmr_done;

  assign in_range = (cpu_addr[31:MEM_AW] == '0);
  assign wb_hit   = wb_valid_q && (wb_addr_q == cpu_addr[MEM_AW-1:0]);

  // Access window timer, shared by read issue and write drain (never overlap)
  mem_wait_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (accept_wr || start_rd),
    .load_val_i (WAIT_W'(WAIT_STATES)),
    .done_o     (tmr_done)
  );

  // Next-state and output decode; a request seen while cpu_ready is high is
  // the one just completed, so it is ignored for that cycle.
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    accept_wr   = 1'b0;
    start_rd    = 1'b0;

    // Close the current SRAM window; a finished drain empties the buffer
    if (tmr_done) begin
      mem_en_d = 1'b0;
      mem_we_d = 1'b0;
      if (mem_we_q) wb_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cpu_req && !ready_q) begin
          if (!in_range) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            if (!cpu_we) rdata_d = '0;
          end else if (cpu_we) begin
            if (wb_valid_q) state_d = STALL;
            else            accept_wr = 1'b1;
          end else if (wb_hit) begin
            ready_d = 1'b1;
            rdata_d = wb_data_q;
          end else if (wb_valid_q) begin
            state_d = STALL;
          end else begin
            start_rd = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        if (tmr_done) state_d = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        ready_d = 1'b1;
        rdata_d = mem_rdata;
        state_d = IDLE;
      end
      STALL: begin
        if (!wb_valid_q) begin
          if (cpu_we) accept_wr = 1'b1;
          else        start_rd  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Posted write: fill the buffer, complete at once, start draining
    if (accept_wr) begin
      wb_valid_d  = 1'b1;
      wb_addr_d   = cpu_addr[MEM_AW-1:0];
      wb_data_d   = cpu_wdata;
      ready_d     = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = cpu_addr[MEM_AW-1:0];
      mem_wdata_d = cpu_wdata;
      state_d     = IDLE;
    end

    // SRAM read: hold the strobe for the whole wait window
    if (start_rd) begin
      mem_en_d   = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = cpu_addr[MEM_AW-1:0];
      state_d    = RD_ISSUE;
    end
  end

  // State, output and write-buffer registers; reset discards a pending write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // The CPU must hold its request while the bridge is still working on it
  a_req_held: assert property (@(posedge clock) disable iff (!reset)
                               (state_q != IDLE) |-> cpu_req);

endmodule : mem_bridge
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_bridge
// Brief   : Self-checking bench for mem_bridge with a strict wait-state SRAM
//           model and an expected-response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_bridge;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int WS = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_err;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clock = ~clock;

  mem_bridge #(.DATA_W(DW), .MEM_AW(AW), .WAIT_STATES(WS)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // SRAM model: data is presented only in the cycle after a full WS+1 window,
  // writes commit at the end of the window; otherwise rdata is garbage.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  bit            sram_init = 1'b0;
  int            win_cnt   = 0;

  always @(posedge clock) begin
    if (!sram_init) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= 32'hA500_0000 + i;
      sram[16]  <= 32'h1234_5678;
      sram_init <= 1'b1;
      mem_rdata <= 32'hBADD_A7A0;
    end else if (mem_en) begin
      if (win_cnt == WS) begin
        if (mem_we) begin
          sram[mem_addr] <= mem_wdata;
          mem_rdata      <= 32'hBADD_A7A0;
        end else begin
          mem_rdata <= sram[mem_addr];
        end
        win_cnt <= 0;
      end else begin
        win_cnt   <= win_cnt + 1;
        mem_rdata <= 32'hBADD_A7A0;
      end
    end else begin
      win_cnt   <= 0;
      mem_rdata <= 32'hBADD_A7A0;
    end
  end

  // Cycle counter and SRAM strobe monitor (sampled mid-cycle)
  int   cyc = 0;
  int   rd_strobes = 0, wr_strobes = 0;
  int   last_wr_cyc = 0, rd_start_cyc = 0;
  logic prev_rd = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_en && mem_we) begin
      wr_strobes  = wr_strobes + 1;
      last_wr_cyc = cyc;
    end
    if (mem_en && !mem_we) begin
      rd_strobes = rd_strobes + 1;
      if (!prev_rd) rd_start_cyc = cyc;
    end
    prev_rd = mem_en && !mem_we;
  end

  // Scoreboard of expected responses
  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for cpu_ready, compare with scoreboard
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    sb.push_back('{we, exp_rdata, exp_err, exp_lat});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!cpu_ready && lat < 50);
    e = sb.pop_front();
    check({tag, "_lat"}, lat, e.lat);
    check({tag, "_err"}, {31'd0, cpu_err}, {31'd0, e.err});
    if (!e.we) check({tag, "_rdata"}, cpu_rdata, e.rdata);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    @(posedge clock); #1;
    check({tag, "_pulse"}, {31'd0, cpu_ready}, 32'd0);
  endtask

  int r0, w0;

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_err",   {31'd0, cpu_err},   32'd0);
    check("rst_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Cold read: strobe three cycles, data at T+5
    r0 = rd_strobes;
    do_req("cold_rd", 1'b0, 32'h10, '0, 32'h1234_5678, 1'b0, 5);
    check("cold_rd_strobes", rd_strobes - r0, 3);

    // Out-of-range write and read: immediate error, no SRAM activity
    r0 = rd_strobes; w0 = wr_strobes;
    do_req("oor_wr", 1'b1, 32'h400, 32'h5A5A_5A5A, '0, 1'b1, 1);
    do_req("oor_rd", 1'b0, 32'h8000_0004, '0, 32'd0, 1'b1, 1);
    repeat (4) @(posedge clock); #1;
    check("oor_strobes", (rd_strobes - r0) + (wr_strobes - w0), 0);
    check("oor_sram0", sram[0], 32'hA500_0000);

    // Posted write then forwarded read of the same address
    r0 = rd_strobes;
    do_req("post_wr", 1'b1, 32'h3, 32'hCAFE_F00D, '0, 1'b0, 1);
    do_req("fwd_rd",  1'b0, 32'h3, '0, 32'hCAFE_F00D, 1'b0, 1);
    repeat (4) @(posedge clock); #1;
    check("fwd_no_rd_strobe", rd_strobes - r0, 0);
    check("fwd_sram3", sram[3], 32'hCAFE_F00D);

    // Back-to-back writes: second stalls behind the first drain
    w0 = wr_strobes;
    do_req("b2b_wr1", 1'b1, 32'h1, 32'h1111_0001, '0, 1'b0, 1);
    do_req("b2b_wr2", 1'b1, 32'h2, 32'h2222_0002, '0, 1'b0, 3);
    repeat (6) @(posedge clock); #1;
    check("b2b_we_cycles", wr_strobes - w0, 6);
    check("b2b_sram1", sram[1], 32'h1111_0001);
    check("b2b_sram2", sram[2], 32'h2222_0002);

    // Read miss during a drain: read window starts after the write window
    r0 = rd_strobes;
    do_req("miss_wr", 1'b1, 32'h7, 32'h7777_7777, '0, 1'b0, 1);
    do_req("miss_rd", 1'b0, 32'h8, '0, 32'hA500_0008, 1'b0, 7);
    check("miss_rd_gap", rd_start_cyc - last_wr_cyc, 2);
    check("miss_rd_strobes", rd_strobes - r0, 3);
    check("miss_sram7", sram[7], 32'h7777_7777);

    // Reset in the middle of a drain discards the buffered write
    do_req("rst_wr", 1'b1, 32'h5, 32'hDEAD_BEEF, '0, 1'b0, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_mem", {30'd0, mem_en, mem_we}, 32'd0);
    check("mid_rst_addr", {22'd0, mem_addr}, 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_rdata", cpu_rdata, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    do_req("rst_rd", 1'b0, 32'h5, '0, 32'hA500_0005, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_bridge
`default_nettype wire
